ks2_serial_adder: RTL and testbench

Digit-serial adder that wraps the 2-bit Kogge-Stone digit cell KS2_new in a sequential datapath. It accepts one WIDTH-bit operand pair and a carry-in through a valid/ready handshake. It feeds the operands to the cell two bits per cycle, registering the cell's carry-out as the next digit's carry-in. It then presents the assembled WIDTH-bit sum and final carry-out through a second valid/ready handshake. The block is the stage directly downstream of the KS2 cell: it consumes sum0/sum1/cout and produces cin.

---
 rtl/ks2_serial_adder.sv | 123 ++++++++++++
 tb/tb_ks2_serial_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ks2_serial_adder.sv
// Digit-serial adder: a WIDTH-bit add built from one 2-bit Kogge-Stone cell (ks2_new).
// The cell handles two bits per cycle. The carry and a shift-in result register live between cycles.

module ks2_new (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic cin,
  output logic sum0,
  output logic sum1,
  output logic cout
);
  logic g0, p0, g1, p1, c1, g10, p10;

  assign g0   = a0 & b0;
  assign p0   = a0 ^ b0;
  assign g1   = a1 & b1;
  assign p1   = a1 ^ b1;
  assign c1   = g0 | (p0 & cin);
  assign sum0 = p0 ^ cin;
  assign sum1 = p1 ^ c1;
  // The group generate/propagate over both bits gives cout directly from cin.
  assign g10  = g1 | (p1 & g0);
  assign p10  = p1 & p0;
  assign cout = g10 | (p10 & cin);
endmodule

module ks2_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Valid does not wait on ready. The producer holds its data stable while valid is high and ready is low.
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, r, r_shift;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             k_sum0, k_sum1, k_cout;

  ks2_new u_cell (
    .a0   (sa[0]),
    .a1   (sa[1]),
    .b0   (sb[0]),
    .b1   (sb[1]),
    .cin  (c),
    .sum0 (k_sum0),
    .sum1 (k_sum1),
    .cout (k_cout)
  );

  // The new digit enters at the top, so after N cycles digit 0 sits at the bottom.
  always_comb begin
    r_shift = r >> 2;
    r_shift[WIDTH-1 -: 2] = {k_sum1, k_sum0};
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_RUN;
      S_RUN:   if (cnt == LAST) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      r     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= b;
            c   <= cin;
            cnt <= '0;
          end
        end
        S_RUN: begin
          sa  <= sa >> 2;
          sb  <= sb >> 2;
          c   <= k_cout;
          r   <= r_shift;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Results are shown only in DONE. This keeps sum/cout stable across the whole valid window.
  assign in_ready  = (state == S_IDLE) & ~rst;
  assign out_valid = (state == S_DONE);
  assign sum       = out_valid ? r : '0;
  assign cout      = out_valid & c;
  assign busy      = (state != S_IDLE);
endmodule

// File: tb/tb_ks2_serial_adder.sv
// Directed and randomized checks of ks2_serial_adder at WIDTH = 16, 8 and 2.
// One clock drives all three instances, and index k selects the instance under test.

module tb_ks2_serial_adder;
  localparam int NR = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid, cin_v, out_ready;
  logic [15:0] a_v[3], b_v[3];
  wire  [2:0]  in_ready, out_valid, cout_v, busy;
  wire  [15:0] sum16;
  wire  [7:0]  sum8;
  wire  [1:0]  sum2;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  ks2_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum16), .cout(cout_v[0]), .busy(busy[0])
  );
  ks2_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum8), .cout(cout_v[1]), .busy(busy[1])
  );
  ks2_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_v[2][1:0]), .b(b_v[2][1:0]), .cin(cin_v[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(sum2), .cout(cout_v[2]), .busy(busy[2])
  );

  function automatic int wid(input int k);
    return (k == 0) ? 16 : (k == 1) ? 8 : 2;
  endfunction

  // Observed result packed as {cout, zero-extended sum}.
  function automatic logic [16:0] res(input int k);
    case (k)
      0:       return {cout_v[0], sum16};
      1:       return {cout_v[1], 8'h00, sum8};
      default: return {cout_v[2], 14'h0, sum2};
    endcase
  endfunction

  function automatic logic [16:0] model(input int k, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    longint m, full;
    m    = (longint'(1) << wid(k)) - 1;
    full = (longint'(a) & m) + (longint'(b) & m) + longint'(ci);
    return {1'((full >> wid(k)) & 1), 16'(full & m)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation with out_ready held high, checking the cycle-exact latency.
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [16:0] exp, input string tag);
    int n;
    n = wid(k) / 2;
    @(negedge clk);
    chk({tag, "_rdy_before"}, in_ready[k], 1'b1);
    a_v[k] = a; b_v[k] = b; cin_v[k] = ci;
    in_valid[k] = 1'b1; out_ready[k] = 1'b1;
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_c1"}, in_ready[k], 1'b0);
    chk({tag, "_busy_c1"}, busy[k], 1'b1);
    repeat (n - 1) begin
      @(negedge clk);
      chk({tag, "_early_valid"}, out_valid[k], 1'b0);
    end
    @(negedge clk);
    chk({tag, "_valid"}, out_valid[k], 1'b1);
    chk({tag, "_result"}, res(k), exp);
    chk({tag, "_rdy_done"}, in_ready[k], 1'b0);
    @(negedge clk);
    chk({tag, "_rdy_after"}, in_ready[k], 1'b1);
    chk({tag, "_valid_after"}, out_valid[k], 1'b0);
  endtask

  // Random traffic with gaps on both handshakes. Every result is matched in order against the expected queue.
  task automatic rand_run(input int k);
    int n_done, n_acc, cyc;
    logic acc;
    logic [16:0] e;
    n_done = 0; n_acc = 0; cyc = 0;
    exp_q.delete();
    in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    while (n_done < NR && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (out_valid[k] && out_ready[k]) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_result", res(k), 17'h1ffff ^ res(k));
        else begin
          e = exp_q.pop_front();
          chk("rnd_result", res(k), e);
        end
        n_done++;
      end
      acc = in_valid[k] && in_ready[k];
      if (acc) begin
        exp_q.push_back(model(k, a_v[k], b_v[k], cin_v[k]));
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (!in_valid[k] || acc) begin
        if (n_acc < NR && $urandom_range(0, 2) != 0) begin
          in_valid[k] = 1'b1;
          a_v[k] = 16'($urandom);
          b_v[k] = 16'($urandom);
          cin_v[k] = 1'($urandom_range(0, 1));
        end else begin
          in_valid[k] = 1'b0;
        end
      end
      out_ready[k] = ($urandom_range(0, 3) != 0);
    end
    chk("rnd_ops_done", n_done, NR);
    chk("rnd_ops_accepted", n_acc, NR);
    chk("rnd_queue_empty", exp_q.size(), 0);
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0; cin_v = '0; out_ready = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0; b_v[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", out_valid[k], 1'b0);
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_in_ready", in_ready[k], 1'b0);
      chk("rst_result", res(k), 17'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", in_ready[0], 1'b1);

    // Basic add and full carry propagation
    do_op(0, 16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, "t1");
    do_op(0, 16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000}, "t2a");
    do_op(0, 16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF}, "t2b");

    // Backpressure: the result is held while out_ready is low, and in_valid is ignored meanwhile
    @(negedge clk);
    a_v[0] = 16'h00FF; b_v[0] = 16'h0001; cin_v[0] = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    for (int i = 0; i < 40 && !out_valid[0]; i++) @(negedge clk);
    chk("bp_valid_rise", out_valid[0], 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", res(0), {1'b0, 16'h0100});
      chk("bp_valid_hold", out_valid[0], 1'b1);
      chk("bp_in_ready", in_ready[0], 1'b0);
      if (i == 1) begin
        a_v[0] = 16'hAAAA; in_valid[0] = 1'b1;
      end else begin
        in_valid[0] = 1'b0;
      end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid[0], 1'b0);
    chk("bp_release_ready", in_ready[0], 1'b1);
    chk("bp_release_busy", busy[0], 1'b0);
    do_op(0, 16'h0F0F, 16'h0101, 1'b1, {1'b0, 16'h1011}, "t3_next");

    // Reset during the third RUN cycle aborts the operation
    @(negedge clk);
    a_v[0] = 16'h7777; b_v[0] = 16'h1111; cin_v[0] = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rr_busy_before", busy[0], 1'b1);
    chk("rr_ready_in_rst", in_ready[0], 1'b0);
    @(negedge clk);
    chk("rr_busy", busy[0], 1'b0);
    chk("rr_valid", out_valid[0], 1'b0);
    chk("rr_result", res(0), 17'h0);
    chk("rr_ready_held", in_ready[0], 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rr_ready_after", in_ready[0], 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("rr_no_output", out_valid[0], 1'b0);
    end
    do_op(0, 16'h0001, 16'h0001, 1'b1, {1'b0, 16'h0003}, "t4_next");

    // WIDTH = 2 single-digit case
    do_op(2, 16'h0003, 16'h0003, 1'b1, {1'b1, 16'h0003}, "t5");
    do_op(1, 16'h00F0, 16'h0010, 1'b0, {1'b1, 16'h0000}, "t5_w8");

    // Randomized traffic at each width
    rand_run(2);
    rand_run(1);
    rand_run(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
